pci_bus_arbiter: RTL and testbench
==================================

PCI_BUS_ARBITER -- requirements
Module: pci_bus_arbiter

Interface
REQ-001 SHALL provide parameters: NUM_MASTERS, default 4, number of requesters (2..8); PARK_MASTER, default 0, index granted when no request; LAT_TIMEOUT, default 16, bus-idle cycles a grantee may take to start.
REQ-002 SHALL provide ports: clk  input  1  sole clock, all logic on posedge.
REQ-003 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide: REQ_  input  NUM_MASTERS  active-low bus requests.
REQ-005 SHALL provide: FRAME_, IRDY_  input  1 each  active-low PCI bus-phase signals.
REQ-006 SHALL provide: GNT_  output  NUM_MASTERS  registered, active-low grants.
REQ-007 SHALL provide: owner  output  $clog2(NUM_MASTERS)  index of current or last grantee.
REQ-008 SHALL provide: parked  output  1  high while GNT_ is parked on PARK_MASTER.
REQ-009 SHALL provide: timeout  output  1  one-cycle pulse when a grantee fails to start.

Function
REQ-010 SHALL define bus_idle = FRAME_ & IRDY_; start = bus_idle in previous cycle and FRAME_ low now.
REQ-011 SHALL implement states PARK, GRANT, BUSY, TURN; GNT_ has at most one bit low in every cycle.
REQ-012 TURN: all GNT_ high for exactly one cycle; at exit, round-robin winner of sampled REQ_ -> GRANT(winner), else -> PARK.
REQ-013 Round-robin: search from (last_grant+1) mod NUM_MASTERS upward, wrapping; last_grant updates on each GRANT entry.
REQ-014 PARK: GNT_[PARK_MASTER] low, parked=1; start -> BUSY owner=PARK_MASTER; else winner==PARK_MASTER -> GRANT directly; else any request -> TURN.
REQ-015 GRANT: GNT_[owner] low; start -> BUSY; REQ_[owner] high while bus_idle -> TURN.
REQ-016 GRANT: idle counter increments each bus_idle cycle, clears on entry; reaching LAT_TIMEOUT -> timeout pulse, TURN, owner skipped this round.
REQ-017 BUSY: GNT_[owner] held while no other REQ_ low; another request pending -> TURN (hidden arbitration), new grantee starts only after bus_idle.
REQ-018 BUSY, bus_idle, no other request: REQ_[owner] low -> GRANT(owner); no requests -> PARK if owner==PARK_MASTER, else TURN.
REQ-019 Switching GNT_ between two different masters SHALL always pass through TURN; same-master regrant SHALL not.
REQ-020 Simultaneous start and timeout in GRANT: start wins, no timeout pulse.
REQ-021 Grant latency: request arriving in PARK with no other activity -> GNT_ low within 2 cycles.

Reset
REQ-022 reset asserted SHALL immediately force GNT_ all ones, state TURN, owner 0, parked 0, timeout 0, counter 0, last_grant NUM_MASTERS-1.
REQ-023 Reset mid-transaction SHALL drop the grant asynchronously; after release, first cycle is TURN.

Structure
REQ-024 Package pci_arb_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-025 Winner search SHALL be a combinational sub-module pci_rr_picker (requests, last_grant -> valid, index).
REQ-026 State, owner, last_grant, counter, GNT_ SHALL be flops in pci_bus_arbiter.

Verification
REQ-027 Reset release, REQ_=4'b1111 -> TURN one cycle, then GNT_=4'b1110, parked=1.
REQ-028 REQ_=4'b0101 held, each master runs 3-cycle transfer -> grants alternate 1,3,1,3 with one all-high GNT_ cycle between.
REQ-029 REQ_[2] low, FRAME_ never falls -> timeout pulse after 16 idle cycles, GNT_[2] released, next requester granted.
REQ-030 Master 0 in BUSY, REQ_[3] falls -> GNT_[0] high, TURN, GNT_[3] low while FRAME_ low; master 3 start only after bus_idle.
REQ-031 Reset pulsed while GNT_=4'b1101 mid-transfer -> GNT_=4'b1111 same cycle, no glitch grant.
REQ-032 All runs: assertion GNT_ one-cold-or-all-high and GNT_ change between masters via all-high cycle.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and default parameters for the PCI bus arbiter.
package pci_arb_pkg;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_GRANT,
        ST_BUSY,
        ST_TURN
    } arb_state_t;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_PARK_MASTER = 0;
    localparam int DEF_LAT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_picker.sv
// Round-robin winner search: first requester after last_grant, wrapping.
module pci_rr_picker
    import pci_arb_pkg::*;
#(
    parameter int  NUM_MASTERS = DEF_NUM_MASTERS,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] requests,
    input  logic [IDX_W-1:0]       last_grant,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    int j;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            j = (int'(last_grant) + k) % NUM_MASTERS;
            if (requests[IDX_W'(j)]) begin
                valid = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// PCI central arbiter: round-robin grants, bus parking, hidden arbitration
// and a latency timeout for grantees that never start a transaction.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int  NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int  PARK_MASTER = DEF_PARK_MASTER,
    parameter int  LAT_TIMEOUT = DEF_LAT_TIMEOUT,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] REQ_,
    input  logic                   FRAME_,
    input  logic                   IRDY_,
    output logic [NUM_MASTERS-1:0] GNT_,
    output logic [IDX_W-1:0]       owner,
    output logic                   parked,
    output logic                   timeout
);

    localparam int               CNT_W    = $clog2(LAT_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_MASTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    arb_state_t             state;
    logic [IDX_W-1:0]       last_grant;
    logic [CNT_W-1:0]       cnt;
    logic                   skip;
    logic                   bus_idle_q;

    logic                   bus_idle;
    logic                   start;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] pick_req;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;

    assign bus_idle = FRAME_ & IRDY_;
    assign start    = bus_idle_q & ~FRAME_;
    assign req      = ~REQ_;
    assign others   = req & ~onehot(owner);
    assign cnt_inc  = cnt + CNT_W'(1);
    // A master that just timed out sits out the arbitration round that follows.
    assign pick_req = skip ? others : req;

    pci_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .requests  (pick_req),
        .last_grant(last_grant),
        .valid     (pick_vld),
        .index     (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_TURN;
            GNT_       <= '1;
            owner      <= '0;
            parked     <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            skip       <= 1'b0;
            bus_idle_q <= 1'b1;
        end else begin
            timeout    <= 1'b0;
            bus_idle_q <= bus_idle;
            case (state)
                ST_TURN: begin
                    skip <= 1'b0;
                    if (pick_vld) begin
                        state      <= ST_GRANT;
                        owner      <= pick_idx;
                        last_grant <= pick_idx;
                        cnt        <= '0;
                        GNT_       <= ~onehot(pick_idx);
                    end else begin
                        state  <= ST_PARK;
                        owner  <= PARK_IDX;
                        parked <= 1'b1;
                        GNT_   <= ~onehot(PARK_IDX);
                    end
                end
                ST_PARK: begin
                    if (start) begin
                        state  <= ST_BUSY;
                        parked <= 1'b0;
                    end else if (pick_vld && pick_idx == PARK_IDX) begin
                        state      <= ST_GRANT;
                        last_grant <= PARK_IDX;
                        cnt        <= '0;
                        parked     <= 1'b0;
                    end else if (|req) begin
                        state  <= ST_TURN;
                        parked <= 1'b0;
                        GNT_   <= '1;
                    end
                end
                ST_GRANT: begin
                    if (start) begin
                        state <= ST_BUSY;
                    end else if (bus_idle && !req[owner]) begin
                        state <= ST_TURN;
                        GNT_  <= '1;
                    end else if (bus_idle) begin
                        if (cnt_inc == CNT_W'(LAT_TIMEOUT)) begin
                            state   <= ST_TURN;
                            GNT_    <= '1;
                            timeout <= 1'b1;
                            skip    <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_BUSY: begin
                    // Any other request releases the grant early; the new
                    // grantee still has to wait for the bus to go idle.
                    if (|others) begin
                        state <= ST_TURN;
                        GNT_  <= '1;
                    end else if (bus_idle) begin
                        if (req[owner]) begin
                            state      <= ST_GRANT;
                            last_grant <= owner;
                            cnt        <= '0;
                        end else if (owner == PARK_IDX) begin
                            state  <= ST_PARK;
                            parked <= 1'b1;
                        end else begin
                            state <= ST_TURN;
                            GNT_  <= '1;
                        end
                    end
                end
                default: begin
                    state <= ST_TURN;
                    GNT_  <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: behavioural grant model, directed scenarios, random traffic.
module tb_pci_bus_arbiter;

    localparam int N    = 4;
    localparam int PARK = 0;
    localparam int LAT  = 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] REQ_   = 4'hF;
    logic       FRAME_ = 1'b1;
    logic       IRDY_  = 1'b1;
    logic [3:0] GNT_;
    logic [1:0] owner;
    logic       parked;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    pci_bus_arbiter #(
        .NUM_MASTERS(N),
        .PARK_MASTER(PARK),
        .LAT_TIMEOUT(LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .REQ_   (REQ_),
        .FRAME_ (FRAME_),
        .IRDY_  (IRDY_),
        .GNT_   (GNT_),
        .owner  (owner),
        .parked (parked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the grant (-1 = nobody), and whether that
    // holder is parked, merely granted, or already running a transaction.
    int m_hold, m_own, m_last, m_idle, m_skip;
    bit m_park, m_busy, m_pidle, m_to;

    function automatic int rr(input logic [3:0] rq);
        for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (rq[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic mreset();
        m_hold = -1; m_own = 0; m_last = N - 1; m_idle = 0; m_skip = -1;
        m_park = 0; m_busy = 0; m_pidle = 1; m_to = 0;
    endtask

    task automatic give(input int w);
        m_hold = w; m_own = w; m_last = w; m_busy = 0; m_park = 0; m_idle = 0;
    endtask

    task automatic release_bus();
        m_hold = -1; m_busy = 0; m_park = 0;
    endtask

    task automatic mstep();
        logic [3:0] r, rq;
        bit idl, st;
        int w;
        r = ~REQ_;
        idl = FRAME_ & IRDY_;
        st = m_pidle && !FRAME_;
        m_to = 0;
        if (m_hold < 0) begin
            rq = r;
            if (m_skip >= 0) rq[m_skip[1:0]] = 1'b0;
            m_skip = -1;
            w = rr(rq);
            if (w >= 0) give(w);
            else begin m_hold = PARK; m_own = PARK; m_park = 1; m_busy = 0; end
        end else if (m_park) begin
            w = rr(r);
            if (st) begin m_park = 0; m_busy = 1; end
            else if (w == PARK) give(PARK);
            else if (r != 0) release_bus();
        end else if (!m_busy) begin
            if (st) m_busy = 1;
            else if (idl && !r[m_hold[1:0]]) release_bus();
            else if (idl) begin
                m_idle++;
                if (m_idle == LAT) begin
                    m_to = 1; m_skip = m_hold; m_idle = 0; release_bus();
                end
            end
        end else begin
            rq = r;
            rq[m_hold[1:0]] = 1'b0;
            if (rq != 0) release_bus();
            else if (idl) begin
                if (r[m_hold[1:0]]) give(m_hold);
                else if (m_hold == PARK) begin m_park = 1; m_busy = 0; end
                else release_bus();
            end
        end
        m_pidle = idl;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) mreset();
            else mstep();
        end
    end

    // Per-cycle comparison against the model plus grant-shape invariants.
    logic [3:0] prev_g = 4'hF;
    initial begin
        logic [3:0] exp_g;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_g = (m_hold < 0) ? 4'hF : ~(4'b0001 << m_hold);
                chk("model_gnt", GNT_, exp_g);
                chk("model_owner", owner, m_own);
                chk("model_parked", parked, m_park);
                chk("model_timeout", timeout, m_to);
                chk("gnt_one_cold", (GNT_ == 4'hF || $countones(~GNT_) == 1), 1);
                chk("gnt_turn_gap", (GNT_ == 4'hF || prev_g == 4'hF || GNT_ == prev_g), 1);
                prev_g = GNT_;
            end
        end
    end

    // Simple bus agent: the granted requester starts a transfer once the bus is idle.
    bit         agent_on = 0;
    bit         ag_rand  = 0;
    bit         ag_stub  = 0;
    int         ag_left  = 0;
    logic [3:0] ag_lastg = 4'hF;

    function automatic int gidx(input logic [3:0] g);
        for (int i = 0; i < N; i++) if (!g[i]) return i;
        return -1;
    endfunction

    task automatic agent();
        bit pidle;
        int h;
        pidle = FRAME_ & IRDY_;
        h = gidx(GNT_);
        if (GNT_ != ag_lastg) begin
            if (GNT_ != 4'hF) ag_stub = ag_rand && ($urandom_range(0, 5) == 0);
            ag_lastg = GNT_;
        end
        if (ag_rand && $urandom_range(0, 5) == 0) begin
            logic [1:0] b;
            b = 2'($urandom_range(0, 3));
            REQ_[b] = ~REQ_[b];
        end
        if (ag_left > 0) begin
            ag_left--;
            FRAME_ = (ag_left <= 1);
            IRDY_  = (ag_left == 0);
        end else if (h >= 0 && !REQ_[h[1:0]] && pidle && !ag_stub) begin
            ag_left = (ag_rand ? $urandom_range(1, 4) : 3) + 1;
            FRAME_ = 1'b0;
            IRDY_  = 1'b0;
        end else begin
            FRAME_ = 1'b1;
            IRDY_  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (agent_on) agent();
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        agent_on = 0; ag_left = 0; ag_lastg = 4'hF; ag_stub = 0;
        FRAME_ = 1'b1; IRDY_ = 1'b1; REQ_ = 4'hF;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic reset_to_park();
        do_reset();
        @(negedge clk);
        chk("rel_turn_gnt", GNT_, 4'hF);
        chk("rel_turn_parked", parked, 0);
        tick();
        @(negedge clk);
        chk("park_gnt", GNT_, 4'b1110);
        chk("park_parked", parked, 1);
        chk("park_owner", owner, 0);
    endtask

    initial begin
        int seq[4];
        int ns, n;
        bit seen;
        logic [3:0] lastg;

        #2 reset = 1'b1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_gnt", GNT_, 4'hF);
        chk("rst_owner", owner, 0);
        chk("rst_parked", parked, 0);
        chk("rst_timeout", timeout, 0);
        reset_to_park();

        // Two masters alternating with 3-cycle transfers.
        REQ_ = 4'b0101;
        agent_on = 1; ag_rand = 0;
        ns = 0; lastg = 4'hF;
        for (int c = 0; c < 200 && ns < 4; c++) begin
            tick();
            @(negedge clk);
            if (GNT_ != 4'hF && GNT_ != lastg) begin
                seq[ns] = gidx(GNT_);
                ns++;
            end
            lastg = GNT_;
        end
        chk("alt_count", ns, 4);
        chk("alt_0", seq[0], 1);
        chk("alt_1", seq[1], 3);
        chk("alt_2", seq[2], 1);
        chk("alt_3", seq[3], 3);

        // Grantee never starts: timeout after LAT idle cycles, next requester wins.
        reset_to_park();
        REQ_ = 4'b1011;
        n = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (c == 5) REQ_ = 4'b1001;
            @(negedge clk);
            if (c == 1) chk("grant_latency", GNT_, 4'b1011);
            if (timeout) seen = 1;
            else if (GNT_ == 4'b1011) n++;
        end
        chk("to_seen", seen, 1);
        chk("to_idle_cycles", n, LAT);
        chk("to_gnt_released", GNT_, 4'hF);
        tick();
        @(negedge clk);
        chk("to_next_gnt", GNT_, 4'b1101);
        chk("to_pulse_len", timeout, 0);

        // Hidden arbitration while master 0 owns the bus.
        reset_to_park();
        REQ_ = 4'b1110; FRAME_ = 1'b0; IRDY_ = 1'b0;
        tick(); @(negedge clk);
        chk("hid_busy_gnt", GNT_, 4'b1110);
        REQ_ = 4'b0111;
        tick(); @(negedge clk);
        chk("hid_turn_gnt", GNT_, 4'hF);
        tick(); @(negedge clk);
        chk("hid_gnt3_frame_low", GNT_, 4'b0111);
        FRAME_ = 1'b1; IRDY_ = 1'b0;
        tick(); @(negedge clk);
        chk("hid_gnt3_last_phase", GNT_, 4'b0111);
        IRDY_ = 1'b1;
        tick(); @(negedge clk);
        FRAME_ = 1'b0; IRDY_ = 1'b0;
        tick(); @(negedge clk);
        chk("hid_m3_busy", GNT_, 4'b0111);
        FRAME_ = 1'b1; IRDY_ = 1'b1; REQ_ = 4'hF;
        tick(); @(negedge clk);
        chk("hid_release", GNT_, 4'hF);
        tick(); @(negedge clk);
        chk("hid_repark", GNT_, 4'b1110);

        // Reset mid-transfer drops the grant at once.
        reset_to_park();
        REQ_ = 4'b1101;
        tick(); tick(); @(negedge clk);
        chk("mid_gnt1", GNT_, 4'b1101);
        FRAME_ = 1'b0; IRDY_ = 1'b0;
        tick(); @(negedge clk);
        chk("mid_busy1", GNT_, 4'b1101);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", GNT_, 4'hF);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_parked", parked, 0);
        tick(); tick();
        reset = 1'b0; FRAME_ = 1'b1; IRDY_ = 1'b1;
        @(negedge clk);
        chk("mid_after_turn", GNT_, 4'hF);
        tick(); @(negedge clk);
        chk("mid_regrant", GNT_, 4'b1101);

        // Random traffic against the model.
        do_reset();
        agent_on = 1; ag_rand = 1;
        repeat (3000) tick();
        agent_on = 0;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
